// File: rtl/mssd_byte_packer_pkg.sv
// Shared types for the demux byte packer.
// Entry layout matches the FIFO word: {port, last, data}.
package mssd_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } packer_state_t;

  typedef struct packed {
    logic [1:0] port;
    logic       last;
    logic [7:0] data;
  } byte_entry_t;

endpackage

// File: rtl/mssd_byte_packer_if.sv
// Byte stream handshake toward the system bus.
// The packer is master; the consumer drives byte_ready.
interface mssd_byte_packer_if;

  logic [7:0] byte_data;
  logic [1:0] byte_port;
  logic       byte_last;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_data,
    output byte_port,
    output byte_last,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_port,
    input  byte_last,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/mssd_byte_fifo.sv
// Show-ahead byte FIFO with a registered head entry.
// Pointers carry an extra MSB to tell full from empty.
module mssd_byte_fifo
  import mssd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  byte_entry_t                   din,
  output byte_entry_t                   dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  byte_entry_t    mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic [AW:0]    rd_nxt;
  logic           do_push;
  logic           do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head tracks the entry at the post-edge read pointer,
  // bypassing the array when the new write lands there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_nxt;
      if (do_push && wr_ptr[AW-1:0] == rd_nxt[AW-1:0])
        dout <= din;
      else if (do_pop)
        dout <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/mssd_byte_packer.sv
// Packs demux payload bits LSB-first into port-tagged bytes
// and queues them for the system bus.
module mssd_byte_packer
  import mssd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pn,
  input  logic                out_valid,
  input  logic                p3,
  input  logic                p2,
  input  logic                p1,
  input  logic                p0,
  input  logic                error,
  mssd_byte_packer_if.master  bus,
  output logic                frame_abort,
  output logic                overflow
);

  localparam int CW = $clog2(BITS_PER_BYTE);
  localparam int AW = $clog2(FIFO_DEPTH);

  packer_state_t              state;
  packer_state_t              state_nxt;
  logic [CW-1:0]              bitcnt;
  logic [BITS_PER_BYTE-1:0]   sr;
  logic [BITS_PER_BYTE-1:0]   stage_data;
  logic [1:0]                 port_q;
  logic                       stage_v;
  logic [3:0]                 pv;
  logic                       bit_in;
  logic                       take;
  logic                       complete;
  logic                       discard;
  logic                       push;
  logic                       pop;
  logic                       drop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [AW:0]                fifo_count;
  byte_entry_t                push_entry;
  byte_entry_t                head;

  assign pv     = {p3, p2, p1, p0};
  assign bit_in = pv[(state == IDLE) ? pn : port_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (out_valid && !error) state_nxt = COLLECT;
      COLLECT: if (error || !out_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    take     = out_valid & ~error;
    push     = stage_v & ~error;
    complete = 1'b0;
    discard  = error & stage_v;
    unique case (state)
      IDLE: ;
      COLLECT: begin
        complete = take &&
                   (bitcnt == CW'(BITS_PER_BYTE - 1));
        discard  = error ? (stage_v || bitcnt != '0)
                         : (!out_valid && bitcnt != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt      <= '0;
      sr          <= '0;
      port_q      <= '0;
      stage_v     <= 1'b0;
      stage_data  <= '0;
      frame_abort <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      frame_abort <= discard;
      if (drop) overflow <= 1'b1;
      if (error || (state == COLLECT && !out_valid)) begin
        bitcnt <= '0;
        sr     <= '0;
      end else if (take) begin
        if (state == IDLE) port_q <= pn;
        bitcnt <= bitcnt + CW'(1);
        sr     <= complete ? '0 : {bit_in, sr[BITS_PER_BYTE-1:1]};
      end
      if (complete) begin
        stage_v    <= 1'b1;
        stage_data <= {bit_in, sr[BITS_PER_BYTE-1:1]};
      end else begin
        stage_v    <= 1'b0;
      end
    end
  end

  // The stop-bit cycle that follows a byte decides its last flag.
  assign push_entry = '{port: port_q, last: ~out_valid, data: stage_data};
  assign pop        = ~fifo_empty & bus.byte_ready;
  assign drop       = push & fifo_full & ~pop;

  mssd_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.byte_valid = (fifo_count != '0);
  assign bus.byte_data  = head.data;
  assign bus.byte_port  = head.port;
  assign bus.byte_last  = head.last;

endmodule

// File: tb/tb_mssd_byte_packer.sv
// Directed and randomized bench for mssd_byte_packer against
// a queue-based byte model.
module tb_mssd_byte_packer;
  import mssd_pkg::*;

  localparam int DEPTH = 4;
  localparam int CLEAN = 0;
  localparam int ERR   = 1;
  localparam int NONE  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pn;
  logic       out_valid;
  logic       p3, p2, p1, p0;
  logic       error;
  logic       frame_abort;
  logic       overflow;

  mssd_byte_packer_if bus ();

  mssd_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pn          (pn),
    .out_valid   (out_valid),
    .p3          (p3),
    .p2          (p2),
    .p1          (p1),
    .p0          (p0),
    .error       (error),
    .bus         (bus),
    .frame_abort (frame_abort),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  byte_entry_t q[$];
  logic        ovf_exp;
  logic        abort_exp;
  logic        rnd_rdy;
  logic [7:0]  frm [4];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_pop    = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("valid", 32'(bus.byte_valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(ovf_exp));
    chk("frame_abort", 32'(frame_abort), 32'(abort_exp));
    abort_exp = 1'b0;
    if (q.size() != 0)
      chk("head", 32'({bus.byte_port, bus.byte_last, bus.byte_data}),
          32'(q[0]));
    if (bus.byte_valid && bus.byte_ready) begin
      n_pop++;
      if (q.size() != 0) void'(q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ov, input logic b,
                       input logic [1:0] port, input logic err);
    logic [3:0] pv;
    pv = 4'($urandom);
    pv[port] = b;
    {p3, p2, p1, p0} = pv;
    pn        = port;
    out_valid = ov;
    error     = err;
    if (rnd_rdy) bus.byte_ready = 1'($urandom);
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 2'($urandom), 1'b0);
  endtask

  task automatic model_push(input logic [1:0] port, input logic last,
                            input logic [7:0] d);
    byte_entry_t e;
    e.port = port;
    e.last = last;
    e.data = d;
    if (q.size() < DEPTH) q.push_back(e);
    else ovf_exp = 1'b1;
  endtask

  task automatic run_frame(input logic [1:0] port, input int nbits,
                           input int mode, input logic rdy_term);
    int last_k;
    last_k = (mode == NONE) ? nbits - 1 : nbits;
    for (int k = 0; k <= last_k; k++) begin
      if (k < nbits) begin
        drive(1'b1, frm[k/8][k%8], port, 1'b0);
      end else begin
        if (rdy_term) bus.byte_ready = 1'b1;
        drive(1'(mode == ERR), 1'($urandom), port, 1'(mode == ERR));
        if (rdy_term) bus.byte_ready = 1'b0;
      end
      if (k > 0 && k % 8 == 0 && !(k == nbits && mode == ERR))
        model_push(port, 1'(k == nbits), frm[k/8-1]);
    end
    if (mode != NONE)
      abort_exp = (mode == ERR) ? 1'(nbits > 0) : 1'(nbits % 8 != 0);
    if (mode == ERR) begin
      drive(1'b1, 1'($urandom), port, 1'b1);
      drive(1'b0, 1'b0, port, 1'b0);
    end
  endtask

  task automatic drain();
    bus.byte_ready = 1'b1;
    idle(2 * DEPTH + 2);
    bus.byte_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_valid", 32'(bus.byte_valid), 32'(0));
    chk("rst_data", 32'(bus.byte_data), 32'(0));
    chk("rst_port", 32'(bus.byte_port), 32'(0));
    chk("rst_last", 32'(bus.byte_last), 32'(0));
    chk("rst_abort", 32'(frame_abort), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    q.delete();
    ovf_exp        = 1'b0;
    abort_exp      = 1'b0;
    out_valid      = 1'b0;
    error          = 1'b0;
    bus.byte_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int p_start;
    int nb;
    int nbits;
    rst = 1'b1;
    pn = 2'd0;
    out_valid = 1'b0;
    {p3, p2, p1, p0} = 4'd0;
    error = 1'b0;
    bus.byte_ready = 1'b0;
    rnd_rdy = 1'b0;
    ovf_exp = 1'b0;
    abort_exp = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // Two-byte frame on port 2, consumer always ready
    bus.byte_ready = 1'b1;
    frm[0] = 8'hA5;
    frm[1] = 8'h3C;
    p_start = n_pop;
    run_frame(2'd2, 16, CLEAN, 1'b0);
    idle(4);
    chk("two_byte_pops", 32'(n_pop - p_start), 32'(2));

    // Five bits then stop: partial byte discarded
    frm[0] = 8'($urandom);
    run_frame(2'($urandom), 5, CLEAN, 1'b0);
    idle(2);
    frm[0] = 8'($urandom);
    run_frame(2'd3, 8, CLEAN, 1'b0);
    idle(3);

    // Five single-byte frames with no consumer
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      frm[0] = 8'($urandom);
      run_frame(2'd1, 8, CLEAN, 1'b0);
    end
    idle(1);
    chk("overflow_set", 32'(overflow), 32'(1));
    p_start = n_pop;
    drain();
    chk("overflow_drain", 32'(n_pop - p_start), 32'(4));

    // Error in the middle of the fourth byte
    do_reset();
    for (int i = 0; i < 4; i++) frm[i] = 8'($urandom);
    run_frame(2'($urandom), 27, ERR, 1'b0);
    idle(1);
    p_start = n_pop;
    drain();
    chk("error_drain", 32'(n_pop - p_start), 32'(3));
    frm[0] = 8'($urandom);
    frm[1] = 8'($urandom);
    bus.byte_ready = 1'b1;
    p_start = n_pop;
    run_frame(2'd0, 16, CLEAN, 1'b0);
    idle(4);
    chk("after_error_pops", 32'(n_pop - p_start), 32'(2));
    bus.byte_ready = 1'b0;

    // Reset mid-byte with the FIFO half full
    for (int i = 0; i < 2; i++) begin
      frm[0] = 8'($urandom);
      run_frame(2'($urandom), 8, CLEAN, 1'b0);
    end
    frm[0] = 8'($urandom);
    run_frame(2'd2, 3, NONE, 1'b0);
    do_reset();
    idle(2);
    frm[0] = 8'($urandom);
    run_frame(2'd1, 8, CLEAN, 1'b0);
    p_start = n_pop;
    drain();
    chk("after_rst_drain", 32'(n_pop - p_start), 32'(1));

    // Full FIFO, push and pop on the same edge
    for (int i = 0; i < 4; i++) begin
      frm[0] = 8'($urandom);
      run_frame(2'($urandom), 8, CLEAN, 1'b0);
    end
    frm[0] = 8'($urandom);
    run_frame(2'd3, 8, CLEAN, 1'b1);
    idle(1);
    chk("full_pushpop_ovf", 32'(overflow), 32'(0));
    p_start = n_pop;
    drain();
    chk("full_pushpop_drain", 32'(n_pop - p_start), 32'(4));

    // Random back-to-back frames with a random consumer
    rnd_rdy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      nb = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) frm[i] = 8'($urandom);
      nbits = (f % 3 == 2) ? $urandom_range(1, nb * 8 - 1) : nb * 8;
      run_frame(2'($urandom), nbits, CLEAN, 1'b0);
    end
    rnd_rdy = 1'b0;
    drain();
    chk("random_empty", 32'(bus.byte_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
